// File: rtl/imu_read_sequencer_pkg.sv
// imu_seq_pkg: shared types and constants for the IMU read sequencer.
//   imu_seq_state_t : sequencer FSM states
//   INIT_CMD        : configuration writes issued once after power-up
//   RD_ADDR         : register read addresses, in shadow-byte order
//                     (pitch low, pitch high, AZ low, AZ high)
package imu_seq_pkg;

    typedef enum logic [2:0] {
        PWR_WAIT,
        INIT_WR,
        INIT_WT,
        IDLE,
        RD_REQ,
        RD_WT,
        PUBLISH
    } imu_seq_state_t;

    localparam int NUM_RD = 4;

    localparam logic [15:0] INIT_CMD [0:3] = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460};
    localparam logic [7:0]  RD_ADDR  [0:3] = '{8'hA2, 8'hA3, 8'hAC, 8'hAD};

endpackage

// File: rtl/imu_read_sequencer_if.sv
// imu_read_sequencer_if: handshake between the sequencer and the SPI master.
//   wrt     : one-cycle transaction start (sequencer -> SPI)
//   cmd     : 16-bit command word, held from wrt until done (sequencer -> SPI)
//   done    : one-cycle completion pulse (SPI -> sequencer)
//   rd_data : response, low byte valid in the done cycle (SPI -> sequencer)
// master = sequencer side, slave = SPI master side.
interface imu_read_sequencer_if;
    logic        wrt;
    logic [15:0] cmd;
    logic        done;
    logic [15:0] rd_data;

    modport master (output wrt, cmd, input done, rd_data);
    modport slave  (input wrt, cmd, output done, rd_data);
endinterface

// File: rtl/imu_read_sequencer_int_edge_sync.sv
// int_edge_sync: brings the asynchronous IMU data-ready line into the clk
// domain through two flops, then a third flop for rising-edge detection.
//   clk, rst_n : clock, asynchronous active-low reset
//   async_in   : raw asynchronous input
//   rise       : one-cycle pulse per synchronized rising edge
module int_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);
    logic sync1, sync2, sync3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= async_in;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign rise = sync2 & ~sync3;
endmodule

// File: rtl/imu_read_sequencer.sv
// imu_read_sequencer: after a power-up delay writes the IMU configuration,
// then on each data-ready interrupt reads pitch rate and Z acceleration as
// four byte reads and publishes them with a one-cycle vld strobe.
//   clk, rst_n : clock, asynchronous active-low reset
//   INT        : asynchronous IMU data-ready
//   spi        : SPI master handshake (wrt/cmd/done/rd_data)
//   vld        : one-cycle strobe, new ptch_rt/AZ sample
//   ptch_rt    : pitch rate {hi, lo}
//   AZ         : Z acceleration {hi, lo}
//   ovr        : sticky, an interrupt was coalesced into a pending one
module imu_read_sequencer
    import imu_seq_pkg::*;
#(
    parameter logic [15:0] INIT_DLY = 16'hFFFF,
    parameter int          NUM_INIT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 INT,
    imu_read_sequencer_if.master spi,
    output logic                 vld,
    output logic [15:0]          ptch_rt,
    output logic [15:0]          AZ,
    output logic                 ovr
);
    localparam logic [2:0] LAST_INIT = 3'(NUM_INIT - 1);
    localparam logic [2:0] LAST_RD   = 3'(NUM_RD - 1);

    imu_seq_state_t  state, nxt;
    logic [15:0]     timer;
    logic [2:0]      idx, idx_nxt;
    logic            pending, rise, clr_pend;
    logic [3:0][7:0] shadow, shadow_nxt;
    logic [7:0]      rd_hi_unused;

    assign rd_hi_unused = spi.rd_data[15:8];

    int_edge_sync u_int_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (INT),
        .rise     (rise)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= PWR_WAIT;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            PWR_WAIT: if (timer == INIT_DLY) nxt = INIT_WR;
            INIT_WR:  nxt = INIT_WT;
            INIT_WT:  if (spi.done) nxt = (idx == LAST_INIT) ? IDLE : INIT_WR;
            IDLE:     if (pending) nxt = RD_REQ;
            RD_REQ:   nxt = RD_WT;
            RD_WT:    if (spi.done) nxt = (idx == LAST_RD) ? PUBLISH : RD_REQ;
            PUBLISH:  nxt = IDLE;
            default:  nxt = PWR_WAIT;
        endcase
    end

    always_comb begin
        spi.wrt = (state == INIT_WR) || (state == RD_REQ);
        vld     = (state == PUBLISH);
    end

    // Index restarts in the states that precede each burst; done only
    // advances it in the two wait states, so stray dones are harmless.
    always_comb begin
        idx_nxt = idx;
        if (state == PWR_WAIT || state == IDLE)
            idx_nxt = 3'd0;
        else if (spi.done && (state == INIT_WT || state == RD_WT))
            idx_nxt = idx + 3'd1;
    end

    // Merged view of the shadow bytes including the byte arriving this
    // cycle, so the final byte reaches the outputs in the PUBLISH cycle.
    always_comb begin
        shadow_nxt = shadow;
        if (state == RD_WT && spi.done)
            shadow_nxt[idx[1:0]] = spi.rd_data[7:0];
    end

    // An edge landing in the cycle IDLE consumes pending is a fresh request,
    // not an overrun.
    assign clr_pend = (state == IDLE) && pending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer   <= '0;
            idx     <= '0;
            shadow  <= '0;
            spi.cmd <= '0;
            ptch_rt <= '0;
            AZ      <= '0;
            pending <= 1'b0;
            ovr     <= 1'b0;
        end else begin
            if (state == PWR_WAIT && timer != INIT_DLY)
                timer <= timer + 16'd1;
            idx    <= idx_nxt;
            shadow <= shadow_nxt;
            if (nxt == INIT_WR)
                spi.cmd <= INIT_CMD[idx_nxt[1:0]];
            else if (nxt == RD_REQ)
                spi.cmd <= {RD_ADDR[idx_nxt[1:0]], 8'h00};
            if (nxt == PUBLISH) begin
                ptch_rt <= {shadow_nxt[1], shadow_nxt[0]};
                AZ      <= {shadow_nxt[3], shadow_nxt[2]};
            end
            pending <= rise | (pending & ~clr_pend);
            ovr     <= ovr | (rise & pending & ~clr_pend);
        end
    end
endmodule
